term_arbiter: RTL
=================

TERM_ARBITER -- requirements
Module: term_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, per-source FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter PUTCHAR_GAP, default 32, idle cycles after a putchar pulse; range 1..2^20-1.
REQ-003 Parameter CLEAR_GAP, default 400000, idle cycles after a clearhome pulse; range 1..2^20-1.
REQ-004 i_clk  in  1  system clock (12 MHz); all logic SHALL be synchronous to its rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_a_tdata  in  8  source A (PC UART) byte.
REQ-007 i_a_tvalid  in  1  source A byte valid.
REQ-008 o_a_tready  out  1  source A ready; a byte transfers on a cycle with i_a_tvalid=1 and o_a_tready=1.
REQ-009 i_b_tdata  in  8  source B (keyboard UART) byte.
REQ-010 i_b_tvalid  in  1  source B byte valid.
REQ-011 o_b_tready  out  1  source B ready; same transfer rule as REQ-008.
REQ-012 o_char  out  8  character for the display controller, registered.
REQ-013 o_putchar  out  1  one-cycle pulse: write o_char at the cursor.
REQ-014 o_clearhome  out  1  one-cycle pulse: clear the screen and home the cursor.
REQ-015 o_busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-016 Each source SHALL have its own FIFO_DEPTH x 8 FIFO, with read/write pointers wrapping modulo FIFO_DEPTH.
REQ-017 o_x_tready SHALL be 1 exactly when FIFO x is not full and i_rst_n=1; no push on a full FIFO, including a cycle with a simultaneous pop.
REQ-018 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave its occupancy unchanged.
REQ-019 FSM states: IDLE, ISSUE, WAIT.
REQ-020 IDLE: if either FIFO is non-empty, grant one FIFO, pop it, latch its head into o_char and go to ISSUE; otherwise stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: when both FIFOs are non-empty, grant the source not granted last; after reset, A has priority.
REQ-022 ISSUE, one cycle:
- if o_char == 8'h0C: pulse o_clearhome and load the gap counter with CLEAR_GAP-1;
- otherwise: pulse o_putchar and load the gap counter with PUTCHAR_GAP-1;
- in both cases go to WAIT.
REQ-023 WAIT: decrement the gap counter each cycle; when it is 0, go to IDLE.
REQ-024 o_putchar and o_clearhome SHALL never be high together and SHALL each be high for exactly one cycle per granted byte.
REQ-025 Latency: a byte accepted into an empty FIFO at cycle t with the FSM in IDLE SHALL be granted at t+1 and pulsed at t+2.
REQ-026 o_char SHALL hold its value from grant until the next grant.
REQ-027 Bytes from one source SHALL be emitted in arrival order; no byte SHALL be dropped or duplicated.

Reset
REQ-028 While i_rst_n=0:
- FSM = IDLE; both FIFOs empty; gap counter = 0; round-robin priority = A;
- o_char = 8'h00; o_putchar = o_clearhome = o_busy = 0; o_a_tready = o_b_tready = 0.
REQ-029 Reset asserted mid-operation (ISSUE or WAIT) SHALL abort immediately. Any pending pulse and all queued bytes are discarded.
REQ-030 In the first cycle after i_rst_n rises, o_a_tready and o_b_tready SHALL be 1.

Verification
REQ-031 Source A sends 8'h41 into an idle block -> o_putchar high exactly at t+2 with o_char=8'h41; o_busy high for PUTCHAR_GAP+1 cycles.
REQ-032 Source B sends 8'h0C -> a single o_clearhome pulse with o_char=8'h0C and no o_putchar; next grant no earlier than CLEAR_GAP cycles after the pulse.
REQ-033 A and B each hold 3 bytes (A: 41,42,43; B: 61,62,63) -> o_char sequence 41,61,42,62,43,63.
REQ-034 Source A pushes FIFO_DEPTH+2 bytes back-to-back while the FSM is held in WAIT -> o_a_tready falls after FIFO_DEPTH accepts; all accepted bytes are later emitted in order.
REQ-035 i_rst_n pulled low during WAIT with both FIFOs non-empty -> all outputs at REQ-028 values; no pulse after release until new bytes arrive.
REQ-036 Simultaneous push and pop on a 1-entry FIFO -> occupancy stays 1 and both bytes are emitted in order.

Source files
------------

// File: rtl/term_arbiter.sv
// Merges two byte streams (PC UART, keyboard UART) into one display-controller
// command stream, with per-source FIFOs, round-robin grant and a post-command gap.

module term_arbiter_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tdata,
    input  logic       i_tvalid,
    output logic       o_tready,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, push, pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign o_empty  = (count == '0);
    // Ready is gated by reset so nothing is accepted while the block is held.
    assign o_tready = i_rst_n & ~full;
    assign push     = i_tvalid & o_tready;
    assign pop      = i_pop & ~o_empty;
    assign o_head   = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_tdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module term_arbiter #(
    parameter int FIFO_DEPTH  = 8,
    parameter int PUTCHAR_GAP = 32,
    parameter int CLEAR_GAP   = 400000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_a_tdata,
    input  logic       i_a_tvalid,
    output logic       o_a_tready,
    input  logic [7:0] i_b_tdata,
    input  logic       i_b_tvalid,
    output logic       o_b_tready,
    output logic [7:0] o_char,
    output logic       o_putchar,
    output logic       o_clearhome,
    output logic       o_busy
);
    localparam logic [19:0] PUT_LOAD = 20'(PUTCHAR_GAP - 1);
    localparam logic [19:0] CLR_LOAD = 20'(CLEAR_GAP - 1);
    localparam logic [7:0]  CH_CLEAR = 8'h0C;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state, state_nxt;
    logic        a_empty, b_empty, pop_a, pop_b;
    logic [7:0]  a_head, b_head;
    logic        prio_b;
    logic [19:0] gap;

    term_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_tdata(i_a_tdata), .i_tvalid(i_a_tvalid), .o_tready(o_a_tready),
        .i_pop(pop_a), .o_head(a_head), .o_empty(a_empty)
    );

    term_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_tdata(i_b_tdata), .i_tvalid(i_b_tvalid), .o_tready(o_b_tready),
        .i_pop(pop_b), .o_head(b_head), .o_empty(b_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop_a     = 1'b0;
        pop_b     = 1'b0;
        case (state)
            IDLE: begin
                // prio_b marks B as preferred when both sources are waiting.
                if (!a_empty && (b_empty || !prio_b)) begin
                    pop_a     = 1'b1;
                    state_nxt = ISSUE;
                end else if (!b_empty) begin
                    pop_b     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (gap == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_putchar   = (state == ISSUE) && (o_char != CH_CLEAR);
    assign o_clearhome = (state == ISSUE) && (o_char == CH_CLEAR);
    assign o_busy      = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_char <= 8'h00;
            prio_b <= 1'b0;
            gap    <= '0;
        end else begin
            if (pop_a) begin
                o_char <= a_head;
                prio_b <= 1'b1;
            end else if (pop_b) begin
                o_char <= b_head;
                prio_b <= 1'b0;
            end
            if (state == ISSUE)
                gap <= (o_char == CH_CLEAR) ? CLR_LOAD : PUT_LOAD;
            else if (state == WAIT && gap != '0)
                gap <= gap - 20'd1;
        end
    end
endmodule
